counter: RTL and testbench

Loadable, trigger-started, auto-reloading down-counter with a shared bidirectional data port. With `we` low, the block samples a load value from `out_or_load`. With `we` high, it drives its current count onto `out_or_load`. After a rising edge on `trig`, it counts down and emits a one-cycle `out_pulse` each time the count wraps through zero. It sits on a shared bus as a programmable periodic pulse/tick generator.

---
 rtl/counter.sv | 62 ++++++
 tb/tb_counter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// Loadable, trigger-started, auto-reloading down-counter on a shared bidirectional bus.
// It drives the count when we_i=1 and samples a load/reload value when we_i=0.
module counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   inout  wire  [WIDTH-1:0] out_or_load_io,
   input  logic             we_i,
   input  logic             trig_i,
   output logic             out_pulse_o
);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rld_q, rld_d;
   logic             run_q, run_d;
   logic             trig_q;
   logic             pulse_q, pulse_d;

   // The bus driver has no clock delay, so a load is visible as soon as we_i rises.
   assign out_or_load_io = we_i ? cnt_q : {WIDTH{1'bz}};
   assign out_pulse_o    = pulse_q;

   always_comb begin
      cnt_d   = cnt_q;
      rld_d   = rld_q;
      run_d   = run_q;
      pulse_d = 1'b0;
      if (!we_i) begin
         cnt_d = out_or_load_io;
         rld_d = out_or_load_io;
         run_d = 1'b0;
      end else if (run_q) begin
         // Zero reloads instead of decrementing, so the period is rld+1 cycles.
         if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
         end else begin
            cnt_d   = rld_q;
            pulse_d = 1'b1;
         end
      end else if (trig_i && !trig_q) begin
         run_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         rld_q   <= '0;
         run_q   <= 1'b0;
         trig_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         rld_q   <= rld_d;
         run_q   <= run_d;
         trig_q  <= trig_i;
         pulse_q <= pulse_d;
      end
   end

endmodule

// File: tb/tb_counter.sv
// Testbench for counter: directed scenarios with literal expectations, then random
// traffic checked every cycle against a closed-form count/phase model.
module tb_counter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       we  = 1'b1;
   logic       trig = 1'b0;
   logic [3:0] drv = 4'd0;
   wire  [3:0] bus;
   logic       pulse;

   int checks = 0;
   int failures = 0;

   // Model: value held while idle, reload value, running flag, edges since start.
   int m_c0 = 0, m_rld = 0, m_k = 0;
   bit m_run = 0, m_tprev = 0;

   assign bus = we ? 4'bzzzz : drv;

   always #5 clk = ~clk;

   counter #(.WIDTH(4)) dut (
      .clk_i(clk),
      .rst_i(rst),
      .out_or_load_io(bus),
      .we_i(we),
      .trig_i(trig),
      .out_pulse_o(pulse)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int m_cnt();
      if (!m_run) return m_c0;
      if (m_k <= m_c0) return m_c0 - m_k;
      return m_rld - ((m_k - m_c0 - 1) % (m_rld + 1));
   endfunction

   function automatic int m_pulse();
      if (!m_run || m_k <= m_c0) return 0;
      return (((m_k - m_c0 - 1) % (m_rld + 1)) == 0) ? 1 : 0;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_c0 = 0; m_rld = 0; m_k = 0; m_run = 0; m_tprev = 0;
      end else begin
         if (!we) begin
            m_c0 = int'(drv); m_rld = int'(drv); m_run = 0; m_k = 0;
         end else if (m_run) begin
            m_k++;
         end else if (trig && !m_tprev) begin
            m_run = 1; m_k = 0;
         end
         m_tprev = trig;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         chk("model_pulse", int'(pulse), m_pulse());
         if (we) chk("model_bus", int'(bus), m_cnt());
      end
   end

   task automatic step(input logic w, input logic [3:0] b, input logic t);
      we = w; drv = b; trig = t;
      @(posedge clk);
      #1;
   endtask

   int seq_exp [12] = '{3, 2, 1, 0, 4, 3, 2, 1, 0, 4, 3, 2};
   int npulse;

   initial begin
      // Reset asserted with we=1: outputs must be zero before any clock edge.
      #2;
      chk("rst_bus", int'(bus), 0);
      chk("rst_pulse", int'(pulse), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Load 5 then 4; the later load wins and holds without a trigger.
      step(1'b0, 4'd5, 1'b0);
      step(1'b0, 4'd4, 1'b0);
      we = 1'b1; #1;
      chk("load_visible", int'(bus), 4);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 4'd0, 1'b0);
         chk("load_hold", int'(bus), 4);
      end

      // Trigger high two cycles: the start edge holds 4, then the periodic count begins.
      step(1'b1, 4'd0, 1'b1);
      chk("start_hold", int'(bus), 4);
      for (int i = 0; i < 12; i++) begin
         // Retrigger pulse at i==7 must not disturb phase.
         step(1'b1, 4'd0, (i == 0 || i == 7) ? 1'b1 : 1'b0);
         $display("seq i=%0d bus=%0d pulse=%0d", i, bus, pulse);
         chk("seq_bus", int'(bus), seq_exp[i]);
         chk("seq_pulse", int'(pulse), (seq_exp[i] == 4 && i > 0) ? 1 : 0);
      end

      // New reload value 11: pulse stays low during load, then period 12.
      step(1'b0, 4'd11, 1'b0);
      chk("load_pulse_low", int'(pulse), 0);
      step(1'b1, 4'd0, 1'b1);
      chk("reload_start", int'(bus), 11);
      npulse = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 4'd0, 1'b0);
         npulse += int'(pulse);
      end
      chk("period12_pulses", npulse, 2);
      chk("period12_phase", int'(bus), 11);

      // Reload 0: pulse every cycle, bus stays 0.
      step(1'b0, 4'd0, 1'b0);
      step(1'b1, 4'd0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd0, 1'b0);
         chk("rld0_pulse", int'(pulse), 1);
         chk("rld0_bus", int'(bus), 0);
      end

      // Reset mid-count, then no counting without a fresh trigger edge.
      step(1'b0, 4'd7, 1'b0);
      step(1'b1, 4'd0, 1'b1);
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd0, 1'b0);
      chk("pre_rst_bus", int'(bus), 5);
      #2 rst = 1'b1;
      #1;
      chk("midrst_bus", int'(bus), 0);
      chk("midrst_pulse", int'(pulse), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 4'd0, 1'b0);
         chk("post_rst_idle", int'(bus), 0);
      end

      // Random traffic checked by the compare process.
      for (int i = 0; i < 2000; i++) begin
         step(($urandom_range(0, 9) != 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0));
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1; #2; rst = 1'b0;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
